// File: rtl/btb_update_scheduler.sv
// rtl/btb_update_scheduler.sv - BTB with 2-bit counters, single-port arbitration, update FIFO and flush sweep
//
// Purpose:
//   Owns a direct-mapped branch target buffer with 2-bit predictor counters.
//   The table has one access port per cycle. IF lookups and the drain of a
//   small update FIFO compete for it. A RUN/SWEEP FSM invalidates the whole
//   table one entry per cycle on flush_btb.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   lookup_req/_pc        IF prediction request and fetch PC
//   lookup_stall          request not granted this cycle (FIFO full, drain wins)
//   rsp_valid             registered response, one cycle after a granted lookup
//   pred_hit/_target      tag hit and predicted target (0 on miss)
//   branchPredict         counter of the hit entry, 2'b01 on miss
//   upd_valid/_pc/_target/_taken  resolved branch from EX
//   upd_ready             update accepted this cycle (combinational)
//   flush_btb             start invalidate sweep
//   sweep_busy            high while sweeping
module btb_update_scheduler #(
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 8,
  parameter int Q_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lookup_req,
  input  logic [31:0] lookup_pc,
  output logic        lookup_stall,
  output logic        rsp_valid,
  output logic        pred_hit,
  output logic [31:0] pred_target,
  output logic [1:0]  branchPredict,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic        upd_ready,
  input  logic        flush_btb,
  output logic        sweep_busy
);

  localparam int N  = 1 << IDX_W;
  localparam int QW = $clog2(Q_DEPTH);

  typedef enum logic {S_RUN = 1'b0, S_SWEEP = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Table storage; only the valid bits need a reset value.
  logic [N-1:0]     valid_q;
  logic [TAG_W-1:0] tag_q [N];
  logic [31:0]      tgt_q [N];
  logic [1:0]       ctr_q [N];

  // Update FIFO
  logic [31:0]      fq_pc_q  [Q_DEPTH];
  logic [31:0]      fq_tgt_q [Q_DEPTH];
  logic [Q_DEPTH-1:0] fq_taken_q;
  logic [QW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [QW:0]      count_q;

  logic fifo_full, fifo_empty;
  logic lookup_grant, drain, push;

  assign fifo_full  = (count_q == (QW+1)'(Q_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = upd_valid && upd_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_RUN: begin
        if (flush_btb) begin
          state_d = S_SWEEP;
          ptr_d   = '0;
        end
      end
      S_SWEEP: begin
        if (flush_btb) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == IDX_W'(N-1)) state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // ---------------- FSM: outputs / port arbitration ----------------
  // A full FIFO must drain or EX updates would be lost; otherwise IF has priority.
  always_comb begin
    lookup_grant = 1'b0;
    drain        = 1'b0;
    lookup_stall = 1'b0;
    upd_ready    = 1'b0;
    sweep_busy   = 1'b0;
    case (state_q)
      S_RUN: begin
        drain        = !fifo_empty && (fifo_full || !lookup_req);
        lookup_grant = lookup_req && !fifo_full;
        lookup_stall = lookup_req && fifo_full;
        upd_ready    = !fifo_full || drain;
      end
      S_SWEEP: begin
        sweep_busy   = 1'b1;
        lookup_grant = lookup_req;
      end
      default: ;
    endcase
  end

  // ---------------- FIFO head decode and write data ----------------
  logic [31:0]      hd_pc, hd_tgt;
  logic             hd_taken, hd_hit;
  logic [IDX_W-1:0] hd_idx;
  logic [TAG_W-1:0] hd_tag;
  logic [1:0]       hd_ctr, wr_ctr;
  logic             tbl_we;

  assign hd_pc    = fq_pc_q[rd_ptr_q];
  assign hd_tgt   = fq_tgt_q[rd_ptr_q];
  assign hd_taken = fq_taken_q[rd_ptr_q];
  assign hd_idx   = hd_pc[IDX_W+1:2];
  assign hd_tag   = hd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign hd_ctr   = ctr_q[hd_idx];
  assign hd_hit   = valid_q[hd_idx] && (tag_q[hd_idx] == hd_tag);
  // A not-taken miss is popped without touching the table.
  assign tbl_we   = drain && (hd_hit || hd_taken);

  always_comb begin
    wr_ctr = hd_ctr;
    if (!hd_hit)       wr_ctr = 2'b10;
    else if (hd_taken) wr_ctr = (hd_ctr == 2'b11) ? 2'b11 : hd_ctr + 2'b01;
    else               wr_ctr = (hd_ctr == 2'b00) ? 2'b00 : hd_ctr - 2'b01;
  end

  // ---------------- Table ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (state_q == S_SWEEP) begin
      valid_q[ptr_q] <= 1'b0;
    end else if (drain && hd_taken) begin
      valid_q[hd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      ctr_q[hd_idx] <= wr_ctr;
      if (hd_taken) begin
        tag_q[hd_idx] <= hd_tag;
        tgt_q[hd_idx] <= hd_tgt;
      end
    end
  end

  // ---------------- FIFO ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (state_q == S_RUN && flush_btb) begin
      // Pending updates refer to entries about to be invalidated.
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (drain) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (QW+1)'(push) - (QW+1)'(drain);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fq_pc_q[wr_ptr_q]    <= upd_pc;
      fq_tgt_q[wr_ptr_q]   <= upd_target;
      fq_taken_q[wr_ptr_q] <= upd_taken;
    end
  end

  // ---------------- Lookup response ----------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  // During a sweep part of the table is still valid; report a miss regardless.
  assign lk_hit = (state_q == S_RUN) && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid     <= 1'b0;
      pred_hit      <= 1'b0;
      pred_target   <= '0;
      branchPredict <= 2'b00;
    end else begin
      rsp_valid <= lookup_grant;
      if (lookup_grant) begin
        pred_hit      <= lk_hit;
        pred_target   <= lk_hit ? tgt_q[lk_idx] : 32'h0;
        branchPredict <= lk_hit ? ctr_q[lk_idx] : 2'b01;
      end
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[31:IDX_W+TAG_W+2], lookup_pc[1:0],
                            hd_pc[31:IDX_W+TAG_W+2], hd_pc[1:0]};

endmodule
